// File: rtl/axi4lite_sys_bridge.sv
// AXI4-Lite slave to simple system register bus bridge.
// One transaction in flight; a watchdog turns a silent bus into SLVERR.
module axi4lite_sys_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            aclk_i,
  input  logic            arst_i,
  input  logic [AW-1:0]   axi_awaddr_i,
  input  logic            axi_awvalid_i,
  output logic            axi_awready_o,
  input  logic [DW-1:0]   axi_wdata_i,
  input  logic [DW/8-1:0] axi_wstrb_i,
  input  logic            axi_wvalid_i,
  output logic            axi_wready_o,
  output logic [1:0]      axi_bresp_o,
  output logic            axi_bvalid_o,
  input  logic            axi_bready_i,
  input  logic [AW-1:0]   axi_araddr_i,
  input  logic            axi_arvalid_i,
  output logic            axi_arready_o,
  output logic [DW-1:0]   axi_rdata_o,
  output logic [1:0]      axi_rresp_o,
  output logic            axi_rvalid_o,
  input  logic            axi_rready_i,
  output logic [AW-1:0]   sys_addr_o,
  output logic [DW-1:0]   sys_wdata_o,
  output logic [DW/8-1:0] sys_sel_o,
  output logic            sys_wen_o,
  output logic            sys_ren_o,
  input  logic [DW-1:0]   sys_rdata_i,
  input  logic            sys_err_i,
  input  logic            sys_ack_i
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_COLLECT, WR_BUS, WR_RESP, RD_BUS, RD_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              aw_got_q, aw_got_d;
  logic              w_got_q, w_got_d;
  logic [AW-1:0]     awaddr_q, awaddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wstrb_q, wstrb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     sys_addr_q, sys_addr_d;
  logic [DW-1:0]     sys_wdata_q, sys_wdata_d;
  logic [DW/8-1:0]   sys_sel_q, sys_sel_d;
  logic              sys_wen_q, sys_wen_d;
  logic              sys_ren_q, sys_ren_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic collect, aw_hs, w_hs, ar_hs, timeout;

  assign collect = (state_q == IDLE) || (state_q == WR_COLLECT);
  assign axi_awready_o = collect && !aw_got_q;
  assign axi_wready_o  = collect && !w_got_q;
  // Write side wins: AR is held off while any write beat is offered.
  assign axi_arready_o = (state_q == IDLE) && !axi_awvalid_i && !axi_wvalid_i;

  assign aw_hs   = axi_awvalid_i && axi_awready_o;
  assign w_hs    = axi_wvalid_i && axi_wready_o;
  assign ar_hs   = axi_arvalid_i && axi_arready_o;
  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    aw_got_d    = aw_got_q;
    w_got_d     = w_got_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    sys_addr_d  = sys_addr_q;
    sys_wdata_d = sys_wdata_q;
    sys_sel_d   = sys_sel_q;
    sys_wen_d   = 1'b0;
    sys_ren_d   = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE, WR_COLLECT: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = axi_awaddr_i;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = axi_wdata_i;
          wstrb_d = axi_wstrb_i;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          state_d     = WR_BUS;
          aw_got_d    = 1'b0;
          w_got_d     = 1'b0;
          cnt_d       = '0;
          sys_wen_d   = 1'b1;
          sys_addr_d  = aw_hs ? axi_awaddr_i : awaddr_q;
          sys_wdata_d = w_hs ? axi_wdata_i : wdata_q;
          sys_sel_d   = w_hs ? axi_wstrb_i : wstrb_q;
        end else if (aw_hs || w_hs) begin
          state_d = WR_COLLECT;
        end else if (ar_hs) begin
          state_d    = RD_BUS;
          cnt_d      = '0;
          sys_ren_d  = 1'b1;
          sys_addr_d = axi_araddr_i;
        end
      end
      WR_BUS: begin
        if (sys_ack_i) begin
          state_d  = WR_RESP;
          bvalid_d = 1'b1;
          bresp_d  = sys_err_i ? 2'b10 : 2'b00;
        end else if (timeout) begin
          state_d  = WR_RESP;
          bvalid_d = 1'b1;
          bresp_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_BUS: begin
        if (sys_ack_i) begin
          state_d  = RD_RESP;
          rvalid_d = 1'b1;
          rdata_d  = sys_rdata_i;
          rresp_d  = sys_err_i ? 2'b10 : 2'b00;
        end else if (timeout) begin
          state_d  = RD_RESP;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_RESP: begin
        if (axi_bready_i) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      RD_RESP: begin
        if (axi_rready_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      sys_addr_q  <= '0;
      sys_wdata_q <= '0;
      sys_sel_q   <= '0;
      sys_wen_q   <= 1'b0;
      sys_ren_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      aw_got_q    <= aw_got_d;
      w_got_q     <= w_got_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      sys_addr_q  <= sys_addr_d;
      sys_wdata_q <= sys_wdata_d;
      sys_sel_q   <= sys_sel_d;
      sys_wen_q   <= sys_wen_d;
      sys_ren_q   <= sys_ren_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign axi_bvalid_o = bvalid_q;
  assign axi_bresp_o  = bresp_q;
  assign axi_rvalid_o = rvalid_q;
  assign axi_rresp_o  = rresp_q;
  assign axi_rdata_o  = rdata_q;
  assign sys_addr_o   = sys_addr_q;
  assign sys_wdata_o  = sys_wdata_q;
  assign sys_sel_o    = sys_sel_q;
  assign sys_wen_o    = sys_wen_q;
  assign sys_ren_o    = sys_ren_q;

endmodule
